// File: rtl/mag_3bit_com.sv
// Registered unsigned magnitude comparator with one-hot result flags and
// three saturating outcome counters (a > b, b > a, a == b).
module mag_3bit_com #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             Ya,
  output logic             Yb,
  output logic             Ye,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_e
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             gt, lt, eq;
  logic             ya_d, yb_d, ye_d, out_valid_d;
  logic             ya_q, yb_q, ye_q, out_valid_q;
  logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_e_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_e_q;

  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = !gt && !lt;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ya_d        = ya_q;
    yb_d        = yb_q;
    ye_d        = ye_q;
    out_valid_d = in_valid;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    cnt_e_d     = cnt_e_q;

    if (in_valid) begin
      ya_d = gt;
      yb_d = lt;
      ye_d = eq;
      if (gt && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
      if (lt && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
      if (eq && cnt_e_q != CNT_MAX) cnt_e_d = cnt_e_q + 1'b1;
    end

    // Clear wins over a coincident count; the flags still update above.
    if (cnt_clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_e_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ya_q        <= 1'b0;
      yb_q        <= 1'b0;
      ye_q        <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      cnt_e_q     <= '0;
    end else begin
      ya_q        <= ya_d;
      yb_q        <= yb_d;
      ye_q        <= ye_d;
      out_valid_q <= out_valid_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      cnt_e_q     <= cnt_e_d;
    end
  end

  assign Ya        = ya_q;
  assign Yb        = yb_q;
  assign Ye        = ye_q;
  assign out_valid = out_valid_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;
  assign cnt_e     = cnt_e_q;

endmodule

// File: tb/tb_mag_3bit_com.sv
// Directed bench for mag_3bit_com: exhaustive sweep, async reset, hold,
// counter saturation and clear/valid collision.
module tb_mag_3bit_com;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       in_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       Ya, Yb, Ye, out_valid;
  logic [7:0] cnt_a, cnt_b, cnt_e;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic     exp_ya = 1'b0, exp_yb = 1'b0, exp_ye = 1'b0, exp_ov = 1'b0;
  int       exp_ca = 0, exp_cb = 0, exp_ce = 0;

  mag_3bit_com #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .Ya(Ya), .Yb(Yb), .Ye(Ye), .out_valid(out_valid),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_e(cnt_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Ya"}, {7'd0, Ya}, {7'd0, exp_ya});
    check({tag, ".Yb"}, {7'd0, Yb}, {7'd0, exp_yb});
    check({tag, ".Ye"}, {7'd0, Ye}, {7'd0, exp_ye});
    check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, exp_ov});
    check({tag, ".cnt_a"}, cnt_a, 8'(exp_ca));
    check({tag, ".cnt_b"}, cnt_b, 8'(exp_cb));
    check({tag, ".cnt_e"}, cnt_e, 8'(exp_ce));
  endtask

  // Apply one cycle of stimulus, advance past the edge, update the reference.
  task automatic step(input logic [2:0] ta, input logic [2:0] tb_v, input logic v, input logic clr);
    a        = ta;
    b        = tb_v;
    in_valid = v;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    exp_ov = v;
    if (v) begin
      exp_ya = (ta > tb_v);
      exp_yb = (ta < tb_v);
      exp_ye = (ta == tb_v);
      if (exp_ya && exp_ca < 255) exp_ca++;
      if (exp_yb && exp_cb < 255) exp_cb++;
      if (exp_ye && exp_ce < 255) exp_ce++;
    end
    if (clr) begin
      exp_ca = 0;
      exp_cb = 0;
      exp_ce = 0;
    end
  endtask

  task automatic model_reset();
    exp_ya = 1'b0; exp_yb = 1'b0; exp_ye = 1'b0; exp_ov = 1'b0;
    exp_ca = 0; exp_cb = 0; exp_ce = 0;
  endtask

  initial begin
    // Reset state
    #1;
    check_all("reset_init");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle cycle: flags stay zero before the first valid sample
    step(3'd0, 3'd0, 1'b0, 1'b0);
    check_all("idle_after_reset");

    // Exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        step(3'(i), 3'(j), 1'b1, 1'b0);
        check_all($sformatf("sweep_a%0d_b%0d", i, j));
        if (i == 5 && j == 3) begin
          check("pt_5_3_Ya", {7'd0, Ya}, 8'd1);
          check("pt_5_3_Yb", {7'd0, Yb}, 8'd0);
          check("pt_5_3_Ye", {7'd0, Ye}, 8'd0);
        end
        if (i == 2 && j == 6) check("pt_2_6_Yb", {7'd0, Yb}, 8'd1);
        if (i == 4 && j == 4) check("pt_4_4_Ye", {7'd0, Ye}, 8'd1);
      end
    end
    check("sweep_end_cnt_a", cnt_a, 8'd28);
    check("sweep_end_cnt_b", cnt_b, 8'd28);
    check("sweep_end_cnt_e", cnt_e, 8'd8);

    // Reset asserted mid-sweep, outputs must clear before the next edge
    for (int k = 0; k < 10; k++) step(3'(k % 8), 3'((k * 3) % 8), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_midstream");
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd0, 3'd0, 1'b0, 1'b0);
    check_all("post_reset_idle");

    // Hold behaviour
    step(3'd7, 3'd0, 1'b1, 1'b0);
    check("hold_load_Ya", {7'd0, Ya}, 8'd1);
    check("hold_load_cnt_a", cnt_a, 8'd1);
    for (int k = 0; k < 3; k++) begin
      step(3'd0, 3'd5, 1'b0, 1'b0);
      check($sformatf("hold%0d_Ya", k), {7'd0, Ya}, 8'd1);
      check($sformatf("hold%0d_out_valid", k), {7'd0, out_valid}, 8'd0);
      check($sformatf("hold%0d_cnt_a", k), cnt_a, 8'd1);
      check_all($sformatf("hold%0d", k));
    end

    // Saturation of cnt_e
    step(3'd0, 3'd0, 1'b0, 1'b1);
    check_all("sat_clear");
    for (int k = 1; k <= 300; k++) begin
      step(3'd1, 3'd1, 1'b1, 1'b0);
      if (k == 254 || k == 255 || k == 256 || k == 300) check_all($sformatf("sat_%0d", k));
    end
    check("sat_final_cnt_e", cnt_e, 8'd255);

    // Clear collides with a valid sample
    step(3'd3, 3'd1, 1'b1, 1'b1);
    check("clr_col_cnt_a", cnt_a, 8'd0);
    check("clr_col_cnt_b", cnt_b, 8'd0);
    check("clr_col_cnt_e", cnt_e, 8'd0);
    check("clr_col_Ya", {7'd0, Ya}, 8'd1);
    check("clr_col_out_valid", {7'd0, out_valid}, 8'd1);
    check_all("clr_col");

    // Counting resumes after the clear
    step(3'd1, 3'd6, 1'b1, 1'b0);
    check("after_clr_cnt_b", cnt_b, 8'd1);
    check_all("after_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
